// File: rtl/dummy_loc_sequencer.sv
// Constant-length shift-position sequencer: mixes real position-RAM locations with
// LFSR dummy positions so every run emits exactly MAX_WEIGHT slots.
module dummy_loc_sequencer #(
  parameter int unsigned N              = 17669,
  parameter int unsigned M              = 15,
  parameter int unsigned MAX_WEIGHT     = 75,
  parameter int unsigned LOG_MAX_WEIGHT = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [LOG_MAX_WEIGHT-1:0] weight_i,
  input  logic [31:0]               seed_i,
  output logic [LOG_MAX_WEIGHT-1:0] loc_addr_o,
  input  logic [M-1:0]              loc_in_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [M-1:0]              out_pos_o,
  output logic                      out_real_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned   LW        = LOG_MAX_WEIGHT;
  localparam logic [LW-1:0] MAX_W     = LW'(MAX_WEIGHT);
  localparam logic [M-1:0]  N_M       = M'(N);
  localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] r_q, rtot_q, s_q, loc_addr_q;
  logic [31:0]   lfsr_q;
  logic          hold_q, pend_q;
  logic [M-1:0]  fifo0_q, fifo1_q;
  logic [1:0]    cnt_q;
  logic          out_valid_q, out_real_q, busy_q, done_q;
  logic [M-1:0]  out_pos_q;

  logic          start_ok, pick_real, slot_open, load, pop, issue;
  logic [1:0]    occ_after;
  logic [M-1:0]  lfsr_low, dummy_pos;
  logic [31:0]   lfsr_step;

  // Next state, slot decision and prefetch control
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    load      = 1'b0;
    slot_open = (!out_valid_q) || out_ready_i;
    pick_real = (r_q == s_q) || ((r_q != '0) && lfsr_q[0]);
    lfsr_low  = lfsr_q[M-1:0];
    dummy_pos = (lfsr_low >= N_M) ? (lfsr_low - N_M) : lfsr_low;
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = PRIME;
        end
      end
      PRIME: state_d = RUN;
      RUN: begin
        // A real slot can only be taken once its location has landed in the FIFO
        load = !hold_q && (s_q != '0) && slot_open && (!pick_real || (cnt_q != 2'd0));
        if (out_valid_q && out_ready_i && (s_q == '0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pop       = load && pick_real;
    // Counting the same-cycle pop keeps the FIFO streaming one location per cycle
    occ_after = cnt_q + 2'(pend_q) - 2'(pop);
    issue     = ((state_q == PRIME) || (state_q == RUN)) &&
                (occ_after < 2'd2) && (loc_addr_q < rtot_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Run counters, LFSR, prefetch FIFO and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      rtot_q      <= '0;
      s_q         <= '0;
      loc_addr_q  <= '0;
      lfsr_q      <= 32'h1;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pos_q   <= '0;
      out_real_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hold_q <= (state_q == PRIME);
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      pend_q <= issue;

      if (start_ok) begin
        r_q        <= (weight_i > MAX_W) ? MAX_W : weight_i;
        rtot_q     <= (weight_i > MAX_W) ? MAX_W : weight_i;
        s_q        <= MAX_W;
        lfsr_q     <= (seed_i == 32'h0) ? 32'h1 : seed_i;
        loc_addr_q <= '0;
      end else begin
        if (issue) loc_addr_q <= loc_addr_q + LW'(1);
        if (load) begin
          s_q    <= s_q - LW'(1);
          lfsr_q <= lfsr_step;
          if (pick_real) r_q <= r_q - LW'(1);
        end
      end

      if (load) begin
        out_valid_q <= 1'b1;
        out_pos_q   <= pick_real ? fifo0_q : dummy_pos;
        out_real_q  <= pick_real;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      // Two-entry FIFO with fifo0_q as head; pend_q marks RAM data arriving now
      case ({pend_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) fifo0_q <= loc_in_i;
          else               fifo1_q <= loc_in_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          fifo0_q <= fifo1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            fifo0_q <= loc_in_i;
          end else begin
            fifo0_q <= fifo1_q;
            fifo1_q <= loc_in_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign loc_addr_o  = loc_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_pos_o   = out_pos_q;
  assign out_real_o  = out_real_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
